ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data RAM between the CPU load/store path (port 0) and a debug/program-loader master (port 1). Each accepted request becomes a fixed three-state transaction (grant, RAM access, response), so the RAM sees at most one access at a time. Round-robin priority applies under contention. The block sits between the CPU datapath's ALU-address/rs2-data outputs and the RAM instance, and returns load data plus a stall for the CPU.

---
 rtl/ram_arbiter.sv | 116 +++++++++++
 tb/tb_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter sharing a single-ported data RAM between the CPU (port 0)
// and a debug/loader master (port 1); each grant runs a fixed grant/access/response sequence.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [1:0]        m0_write_flag,
    input  logic [2:0]        m0_read_flag,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic [1:0]        m1_write_flag,
    input  logic [2:0]        m1_read_flag,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] write_ram_data,
    output logic [1:0]        write_ram_flag,
    output logic [2:0]        read_ram_flag,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q;
    logic              prio_q;   // port granted last; the other port wins a tie
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        wflag_q;
    logic [2:0]        rflag_q;
    logic [DATA_W-1:0] rdata_q;

    logic any_req;
    logic win;
    logic in_idle;
    logic in_access;
    logic in_resp;

    always_comb begin
        any_req = m0_req | m1_req;
        win     = 1'b0;
        if (m0_req && m1_req) begin
            win = ~prio_q;
        end else begin
            win = m1_req;
        end
    end

    // Everything visible to the masters or the RAM is gated by reset so an aborted
    // transaction never commits a write or returns a completion.
    assign in_idle   = rst && (state_q == StIdle);
    assign in_access = rst && (state_q == StAccess);
    assign in_resp   = rst && (state_q == StResp);

    assign m0_gnt = in_idle && m0_req && !win;
    assign m1_gnt = in_idle && m1_req && win;

    assign ram_addr       = addr_q;
    assign write_ram_data = wdata_q;
    assign write_ram_flag = in_access ? wflag_q : 2'd0;
    assign read_ram_flag  = in_access ? rflag_q : 3'd0;

    assign m0_rvalid = in_resp && !owner_q;
    assign m1_rvalid = in_resp && owner_q;
    assign m0_rdata  = owner_q ? '0 : rdata_q;
    assign m1_rdata  = owner_q ? rdata_q : '0;

    assign m0_stall = rst && (m0_req || (!owner_q && (state_q != StIdle) && !m0_rvalid));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            prio_q  <= 1'b1;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wflag_q <= 2'd0;
            rflag_q <= 3'd0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        owner_q <= win;
                        addr_q  <= win ? m1_addr : m0_addr;
                        wdata_q <= win ? m1_wdata : m0_wdata;
                        wflag_q <= win ? m1_write_flag : m0_write_flag;
                        rflag_q <= win ? m1_read_flag : m0_read_flag;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    rdata_q <= (rflag_q != 3'd0) ? ram_out : '0;
                    state_q <= StResp;
                end
                StResp: begin
                    prio_q  <= owner_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM whose unwritten words read
// back as 0x1000_0000 + word index.
module tb_ram_arbiter;

    localparam logic [1:0] WrWord = 2'd3;
    localparam logic [2:0] RdWord = 3'd3;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req;
    logic [1:0]  m0_write_flag, m1_write_flag;
    logic [2:0]  m0_read_flag, m1_read_flag;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] ram_addr, write_ram_data, ram_out;
    logic [1:0]  write_ram_flag;
    logic [2:0]  read_ram_flag;

    int total;
    int bad;

    logic        tb_init;
    logic [31:0] mem [0:255];
    logic [255:0] wr_valid;
    logic [7:0]  idx;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req         (m0_req),
        .m0_write_flag  (m0_write_flag),
        .m0_read_flag   (m0_read_flag),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_rdata       (m0_rdata),
        .m0_stall       (m0_stall),
        .m1_req         (m1_req),
        .m1_write_flag  (m1_write_flag),
        .m1_read_flag   (m1_read_flag),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_rdata       (m1_rdata),
        .ram_addr       (ram_addr),
        .write_ram_data (write_ram_data),
        .write_ram_flag (write_ram_flag),
        .read_ram_flag  (read_ram_flag),
        .ram_out        (ram_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign idx     = ram_addr[9:2];
    assign ram_out = wr_valid[idx] ? mem[idx] : (32'h1000_0000 + {24'd0, idx});

    always @(posedge clk) begin
        if (tb_init) begin
            wr_valid <= '0;
        end else if (write_ram_flag != 2'd0) begin
            mem[idx]      <= write_ram_data;
            wr_valid[idx] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tb_init = 1'b1;
        rst = 1'b0;
        m0_req = 1'b1; m0_write_flag = WrWord; m0_read_flag = 3'd0;
        m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
        m1_req = 1'b0; m1_write_flag = 2'd0; m1_read_flag = 3'd0;
        m1_addr = 32'h0; m1_wdata = 32'h0;

        // Reset held two cycles with m0 requesting: everything forced quiet.
        for (int i = 0; i < 2; i++) begin
            sample;
            check_eq("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
            check_eq("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
            check_eq("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
            check_eq("rst_wflag", {30'd0, write_ram_flag}, 32'd0);
            check_eq("rst_rflag", {29'd0, read_ram_flag}, 32'd0);
            check_eq("rst_stall", {31'd0, m0_stall}, 32'd0);
            step;
            tb_init = 1'b0;
        end
        rst = 1'b1;

        // Port-0 word store to 0x10.
        sample;
        check_eq("st_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
        check_eq("st_wflag_n", {30'd0, write_ram_flag}, 32'd0);
        check_eq("st_stall_n", {31'd0, m0_stall}, 32'd1);
        step;
        m0_req = 1'b0;
        sample;
        check_eq("st_wflag_n1", {30'd0, write_ram_flag}, {30'd0, WrWord});
        check_eq("st_addr", ram_addr, 32'h10);
        check_eq("st_wdata", write_ram_data, 32'hDEAD_BEEF);
        check_eq("st_gnt_n1", {30'd0, m0_gnt, m1_gnt}, 32'd0);
        check_eq("st_stall_n1", {31'd0, m0_stall}, 32'd1);
        step;
        sample;
        check_eq("st_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
        check_eq("st_wflag_n2", {30'd0, write_ram_flag}, 32'd0);
        check_eq("st_rdata", m0_rdata, 32'd0);
        check_eq("st_stall_n2", {31'd0, m0_stall}, 32'd0);
        step;

        // Port-0 word load of 0x10 returns the stored value.
        m0_req = 1'b1; m0_write_flag = 2'd0; m0_read_flag = RdWord;
        sample;
        check_eq("ld_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
        step;
        m0_req = 1'b0;
        sample;
        check_eq("ld_rflag", {29'd0, read_ram_flag}, {29'd0, RdWord});
        check_eq("ld_wflag", {30'd0, write_ram_flag}, 32'd0);
        step;
        sample;
        check_eq("ld_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
        check_eq("ld_rdata", m0_rdata, 32'hDEAD_BEEF);
        check_eq("ld_m1_rdata", m1_rdata, 32'd0);
        step;

        // Fresh reset, then both ports read continuously: grants alternate from port 0.
        rst = 1'b0;
        step;
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h40;
        m1_req = 1'b1; m1_read_flag = RdWord; m1_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            sample;
            check_eq($sformatf("cont_gnt%0d", k), {30'd0, m0_gnt, m1_gnt},
                     (k % 2 == 0) ? 32'd2 : 32'd1);
            step;
            sample;
            check_eq($sformatf("cont_busy_gnt%0d", k), {30'd0, m0_gnt, m1_gnt}, 32'd0);
            step;
            sample;
            check_eq($sformatf("cont_rvalid%0d", k), {30'd0, m0_rvalid, m1_rvalid},
                     (k % 2 == 0) ? 32'd2 : 32'd1);
            check_eq($sformatf("cont_m0_rdata%0d", k), m0_rdata,
                     (k % 2 == 0) ? 32'h1000_0010 : 32'd0);
            check_eq($sformatf("cont_m1_rdata%0d", k), m1_rdata,
                     (k % 2 == 0) ? 32'd0 : 32'h1000_0020);
            step;
        end

        // Lone port-1 requester after it was granted last: never blocked.
        m0_req = 1'b0;
        m1_addr = 32'h84;
        for (int k = 0; k < 3; k++) begin
            sample;
            check_eq($sformatf("lone_gnt%0d", k), {30'd0, m0_gnt, m1_gnt}, 32'd1);
            step;
            step;
            sample;
            check_eq($sformatf("lone_rvalid%0d", k), {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
            check_eq($sformatf("lone_rdata%0d", k), m1_rdata, 32'h1000_0021);
            step;
        end
        m1_req = 1'b0;

        // No-op request: full sequence, no RAM access, rdata cleared.
        m0_req = 1'b1; m0_write_flag = 2'd0; m0_read_flag = 3'd0; m0_addr = 32'h30;
        sample;
        check_eq("nop_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
        check_eq("nop_stall_n", {31'd0, m0_stall}, 32'd1);
        step;
        m0_req = 1'b0;
        sample;
        check_eq("nop_flags", {27'd0, write_ram_flag, read_ram_flag}, 32'd0);
        check_eq("nop_stall_n1", {31'd0, m0_stall}, 32'd1);
        step;
        sample;
        check_eq("nop_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
        check_eq("nop_rdata", m0_rdata, 32'd0);
        check_eq("nop_stall_n2", {31'd0, m0_stall}, 32'd0);
        step;

        // Port-1 write to 0x20 aborted by reset in its access cycle.
        m1_req = 1'b1; m1_write_flag = WrWord; m1_read_flag = 3'd0;
        m1_addr = 32'h20; m1_wdata = 32'h55AA_55AA;
        sample;
        check_eq("abt_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
        step;
        m1_req = 1'b0;
        rst = 1'b0;
        sample;
        check_eq("abt_wflag", {30'd0, write_ram_flag}, 32'd0);
        check_eq("abt_rvalid_n1", {31'd0, m1_rvalid}, 32'd0);
        step;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample;
            check_eq("abt_rvalid_after", {31'd0, m1_rvalid}, 32'd0);
            check_eq("abt_wflag_after", {30'd0, write_ram_flag}, 32'd0);
            step;
        end
        check_eq("abt_mem_untouched", {31'd0, wr_valid[8]}, 32'd0);

        // Back in IDLE: immediate grant, and 0x20 still holds its original contents.
        m0_req = 1'b1; m0_read_flag = RdWord; m0_addr = 32'h20;
        sample;
        check_eq("post_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
        step;
        m0_req = 1'b0;
        step;
        sample;
        check_eq("post_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
        check_eq("post_rdata", m0_rdata, 32'h1000_0008);
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
